// File: rtl/mlp_top.sv
// Streaming int8 vector core: buffers a 64/128-element vector, applies a
// requantizing ReLU with a runtime Q4.8 scale, then streams results out.
module mlp_top #(
  parameter int DATA_SIZE = 32,
  parameter int MAX_LEN   = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [11:0]          scaling_factor,
  input  logic                 ready,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] ofmap,
  output logic                 done
);

  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, next_state;

  logic [7:0]  vbuf [MAX_LEN];
  logic [AW:0] cnt;
  logic        len;
  logic [11:0] sf;

  logic [AW:0] last_word, last_elem, n_elems;
  logic [7:0]  x, y;
  logic signed [20:0] prod, r;

  assign last_word = len ? (AW+1)'(MAX_LEN/4 - 1) : (AW+1)'(MAX_LEN/8 - 1);
  assign last_elem = len ? (AW+1)'(MAX_LEN - 1)   : (AW+1)'(MAX_LEN/2 - 1);
  assign n_elems   = len ? (AW+1)'(MAX_LEN)       : (AW+1)'(MAX_LEN/2);

  // Requantize: round half-up via +128 before the arithmetic shift, then clamp to [0,127].
  assign x    = vbuf[cnt[AW-1:0]];
  assign prod = 21'(signed'(x)) * 21'(signed'({1'b0, sf}));
  assign r    = (prod + 21'sd128) >>> 8;

  always_comb begin
    y = r[7:0];
    if (r < 21'sd0)
      y = 8'd0;
    else if (r > 21'sd127)
      y = 8'd127;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ready) next_state = LOAD;
      LOAD:    if (cnt == last_word) next_state = COMPUTE;
      COMPUTE: if (cnt == last_elem) next_state = OUTPUT;
      OUTPUT:  if (cnt == n_elems) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // OUTPUT spends one extra cycle after the last element so valid drops before IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      ofmap <= '0;
      len   <= 1'b0;
      sf    <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      ofmap <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ready) begin
            len <= mode;
            sf  <= scaling_factor;
          end
        end
        LOAD:    cnt <= (cnt == last_word) ? '0 : cnt + 1'b1;
        COMPUTE: begin
          if (cnt == last_elem) begin
            cnt  <= '0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (cnt != n_elems) begin
            valid <= 1'b1;
            ofmap <= {{(DATA_SIZE-8){1'b0}}, x};
            cnt   <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int unsigned k = 0; k < 4; k++)
        vbuf[{cnt[AW-3:0], 2'(k)}] <= data_in[8*k +: 8];
    end else if (state == COMPUTE) begin
      vbuf[cnt[AW-1:0]] <= y;
    end
  end

endmodule

// File: tb/tb_mlp_top.sv
// Scoreboard bench for mlp_top: expected elements are queued at stimulus time
// and popped against ofmap on every valid cycle.
module tb_mlp_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [11:0] scaling_factor;
  logic        ready;
  logic [31:0] data_in;
  logic        valid;
  logic [31:0] ofmap;
  logic        done;

  mlp_top #(.DATA_SIZE(32), .MAX_LEN(128)) dut (
    .clk(clk), .rst(rst), .mode(mode), .scaling_factor(scaling_factor),
    .ready(ready), .data_in(data_in), .valid(valid), .ofmap(ofmap), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int out_cnt = 0;
  int ready_cyc = 0;
  int xv[128];
  logic [7:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] model(input int x, input int sf);
    int p, rr;
    p  = x * sf;
    rr = (p + 128) >>> 8;
    if (rr < 0) return 8'd0;
    if (rr > 127) return 8'd127;
    return 8'(rr);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      out_cnt++;
      if (q.size() == 0) check("extra_valid", 32'd1, 32'd0);
      else check("ofmap", ofmap, {24'b0, q.pop_front()});
    end else begin
      check("ofmap_idle", ofmap, 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic run_vec(input logic m, input int sf, input int abort_at, input bit poke);
    int n;
    n = m ? 128 : 64;
    done_cnt = 0;
    out_cnt = 0;
    ready = 1'b1;
    mode = m;
    scaling_factor = 12'(sf);
    ready_cyc = cyc + 1;
    if (abort_at < 0)
      for (int i = 0; i < n; i++) q.push_back(model(xv[i], sf));
    @(negedge clk);
    ready = 1'b0;
    mode = ~m;
    scaling_factor = 12'($urandom);
    for (int w = 0; w < n / 4; w++) begin
      data_in = {8'(xv[4*w+3]), 8'(xv[4*w+2]), 8'(xv[4*w+1]), 8'(xv[4*w])};
      if (w == abort_at) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_valid", 32'(out_cnt), 32'd0);
        return;
      end
      @(negedge clk);
    end
    data_in = $urandom;
    for (int i = 0; i < 3 * n + 50 && (q.size() != 0 || out_cnt == 0); i++) begin
      ready = poke && (i == 10 || i == n + 20);
      @(negedge clk);
    end
    ready = 1'b0;
    check("drain", 32'(q.size()), 32'd0);
    check("out_cnt", 32'(out_cnt), 32'(n));
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("done_lat", 32'(done_cyc - ready_cyc), 32'(n / 4 + n));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    mode = 1'b0;
    scaling_factor = '0;
    ready = 1'b0;
    data_in = '0;
    repeat (5) @(negedge clk);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ofmap", ofmap, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_done", 32'(done_cnt), 32'd0);
    check("idle_valid", 32'(out_cnt), 32'd0);

    for (int i = 0; i < 64; i++) xv[i] = i - 32;
    run_vec(1'b0, 256, -1, 1'b0);

    for (int i = 0; i < 64; i++) xv[i] = 3;
    run_vec(1'b0, 384, -1, 1'b0);
    for (int i = 0; i < 64; i++) xv[i] = 1;
    run_vec(1'b0, 128, -1, 1'b0);
    for (int i = 0; i < 64; i++) xv[i] = 127;
    run_vec(1'b0, 4095, -1, 1'b0);
    for (int i = 0; i < 64; i++) xv[i] = -128;
    run_vec(1'b0, 4095, -1, 1'b0);
    for (int i = 0; i < 64; i++) xv[i] = int'($urandom_range(255)) - 128;
    run_vec(1'b0, 0, -1, 1'b0);

    for (int i = 0; i < 128; i++) xv[i] = i;
    run_vec(1'b1, 256, -1, 1'b0);

    for (int i = 0; i < 128; i++) xv[i] = int'($urandom_range(255)) - 128;
    run_vec(1'b1, int'($urandom_range(4095)), -1, 1'b1);

    for (int i = 0; i < 64; i++) xv[i] = int'($urandom_range(255)) - 128;
    run_vec(1'b0, 300, 7, 1'b0);
    run_vec(1'b0, 200, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
